// File: rtl/trafficlight_monitor_if.sv
// Lamp and fault bundle between the traffic-light controller side and the
// safety monitor.
interface trafficlight_monitor_if;
   logic       LaR, LaY, LaG;
   logic       LbR, LbY, LbG;
   logic       clr_fault;
   logic [5:0] fault_vec;
   logic       fault;
   logic       force_red;

   modport master (
      output LaR, LaY, LaG, LbR, LbY, LbG, clr_fault,
      input  fault_vec, fault, force_red
   );

   modport slave (
      input  LaR, LaY, LaG, LbR, LbY, LbG, clr_fault,
      output fault_vec, fault, force_red
   );
endinterface

// File: rtl/trafficlight_monitor.sv
// Safety monitor on the two-road lamp outputs: encoding, conflict, colour
// sequence and phase duration checks with sticky faults and an all-red request.
module trafficlight_monitor #(
   parameter int YELLOW_CYCLES = 2500,
   parameter int MIN_GREEN     = 2500,
   parameter int CNT_W         = 32
) (
   input logic                  clk,
   input logic                  rstn,
   trafficlight_monitor_if.slave bus
);
   typedef enum logic [1:0] {
      C_R = 2'd0,
      C_Y = 2'd1,
      C_G = 2'd2
   } colour_e;

   localparam logic [CNT_W-1:0] YEL  = CNT_W'(YELLOW_CYCLES);
   localparam logic [CNT_W-1:0] MING = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [1:0][2:0]       lamps;
   logic [1:0]            oh;
   logic [1:0][1:0]       col;
   logic [1:0]            seq_f;
   logic [1:0]            tim_f;
   logic                  enc_f;
   logic                  conf_f;
   logic [5:0]            det;

   logic [1:0]            valid_q, valid_d;
   logic [1:0][1:0]       prev_q, prev_d;
   logic [1:0][CNT_W-1:0] dur_q, dur_d;
   logic [5:0]            fault_vec_q, fault_vec_d;
   logic                  fault_q;

   assign lamps[0] = {bus.LaR, bus.LaY, bus.LaG};
   assign lamps[1] = {bus.LbR, bus.LbY, bus.LbG};

   always_comb begin
      oh  = 2'b11;
      col = {C_R, C_R};
      for (int r = 0; r < 2; r++) begin
         unique case (lamps[r])
            3'b100:  col[r] = C_R;
            3'b010:  col[r] = C_Y;
            3'b001:  col[r] = C_G;
            default: oh[r]  = 1'b0;
         endcase
      end
   end

   always_comb begin
      valid_d = valid_q;
      prev_d  = prev_q;
      dur_d   = dur_q;
      seq_f   = 2'b00;
      tim_f   = 2'b00;
      enc_f   = ~&oh;
      conf_f  = &oh && (col[0] != C_R) && (col[1] != C_R);
      for (int r = 0; r < 2; r++) begin
         if (!oh[r]) begin
            valid_d[r] = 1'b0;
         end else if (!valid_q[r]) begin
            valid_d[r] = 1'b1;
            prev_d[r]  = col[r];
            dur_d[r]   = ONE;
         end else if (col[r] != prev_q[r]) begin
            seq_f[r] = !((prev_q[r] == C_G && col[r] == C_Y) ||
                         (prev_q[r] == C_Y && col[r] == C_R) ||
                         (prev_q[r] == C_R && col[r] == C_G));
            // Overlong yellow was already flagged while it was still on.
            if (prev_q[r] == C_G && col[r] == C_Y && dur_q[r] < MING)
               tim_f[r] = 1'b1;
            if (prev_q[r] == C_Y && col[r] == C_R && dur_q[r] < YEL)
               tim_f[r] = 1'b1;
            prev_d[r] = col[r];
            dur_d[r]  = ONE;
         end else begin
            if (col[r] == C_Y && dur_q[r] == YEL)
               tim_f[r] = 1'b1;
            if (dur_q[r] != '1)
               dur_d[r] = dur_q[r] + ONE;
         end
      end
      det         = {tim_f[1], tim_f[0], seq_f[1], seq_f[0], conf_f, enc_f};
      fault_vec_d = (bus.clr_fault ? 6'd0 : fault_vec_q) | det;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q     <= 2'b00;
         prev_q      <= {C_R, C_R};
         dur_q       <= '0;
         fault_vec_q <= 6'd0;
         fault_q     <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         prev_q      <= prev_d;
         dur_q       <= dur_d;
         fault_vec_q <= fault_vec_d;
         fault_q     <= |fault_vec_d;
      end
   end

   assign bus.fault_vec = fault_vec_q;
   assign bus.fault     = fault_q;
   assign bus.force_red = fault_q;
endmodule
